// File: rtl/comparator.sv
// Registered 2-bit unsigned magnitude comparator with one-hot X (A>B), Y (A==B), Z (A<B).
// Optional saturating equality counter eq_cnt is built only when COMPARATOR_STATS_EN is defined.
module comparator #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             A1,
    input  logic             A0,
    input  logic             B1,
    input  logic             B0,
    output logic             X,
    output logic             Y,
    output logic             Z
`ifdef COMPARATOR_STATS_EN
    ,
    output logic [CNT_W-1:0] eq_cnt
`endif
);

    if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
        $error("comparator: CNT_W must be in 1..32");
    end

    logic [1:0] a_vec;
    logic [1:0] b_vec;
    logic [1:0] bit_gt;
    logic [1:0] bit_eq;
    logic       gt_next;
    logic       eq_next;
    logic       lt_next;

    assign a_vec = {A1, A0};
    assign b_vec = {B1, B0};

    for (genvar gi = 0; gi < 2; gi++) begin : g_bit
        assign bit_gt[gi] = a_vec[gi] & ~b_vec[gi];
        assign bit_eq[gi] = ~(a_vec[gi] ^ b_vec[gi]);
    end

    // MSB decides unless the MSBs match, then the LSB decides.
    always_comb begin
        gt_next = bit_gt[1] | (bit_eq[1] & bit_gt[0]);
        eq_next = &bit_eq;
        lt_next = ~gt_next & ~eq_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            X <= 1'b0;
            Y <= 1'b0;
            Z <= 1'b0;
        end else begin
            X <= gt_next;
            Y <= eq_next;
            Z <= lt_next;
        end
    end

`ifdef COMPARATOR_STATS_EN
    // Counts on the same edge that loads Y, holding at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eq_cnt <= '0;
        end else if (eq_next && (eq_cnt != {CNT_W{1'b1}})) begin
            eq_cnt <= eq_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_comparator.sv
// Directed self-checking bench for comparator: reset, exhaustive sweep, one-hot, latency, stats.
`timescale 1ns/100ps
module tb_comparator;

`ifdef COMPARATOR_STATS_EN
    localparam int CNT_W = 2;
`else
    localparam int CNT_W = 8;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic A1 = 1'b0, A0 = 1'b0, B1 = 1'b0, B0 = 1'b0;
    logic X, Y, Z;
`ifdef COMPARATOR_STATS_EN
    logic [CNT_W-1:0] eq_cnt;
`endif

    int checks = 0;
    int errors = 0;
    logic onehot_en = 1'b0;

    always #1 clk = ~clk;

    comparator #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A1    (A1),
        .A0    (A0),
        .B1    (B1),
        .B0    (B0),
        .X     (X),
        .Y     (Y),
        .Z     (Z)
`ifdef COMPARATOR_STATS_EN
        ,
        .eq_cnt(eq_cnt)
`endif
    );

    always @(negedge clk) begin
        if (onehot_en) begin
            checks++;
            if ((32'(X) + 32'(Y) + 32'(Z)) !== 32'd1) begin
                errors++;
                $display("FAIL onehot t=%0t XYZ=%b%b%b required exactly one set", $time, X, Y, Z);
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b1;
        {A1, A0, B1, B0} = 4'b1001;     // A=2, B=1
        repeat (3) @(negedge clk);
        checks++;
        if ({X, Y, Z} !== 3'b100) begin
            errors++;
            $display("FAIL reset_pre XYZ=%b required 100", {X, Y, Z});
        end
        @(posedge clk);
        onehot_en = 1'b0;
        #0.4 rst_n = 1'b0;
        #0.2;
        checks++;
        if ({X, Y, Z} !== 3'b000) begin
            errors++;
            $display("FAIL reset_async XYZ=%b required 000", {X, Y, Z});
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({X, Y, Z} !== 3'b000) begin
            errors++;
            $display("FAIL reset_hold XYZ=%b required 000", {X, Y, Z});
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({X, Y, Z} !== 3'b100) begin
            errors++;
            $display("FAIL reset_release XYZ=%b required 100", {X, Y, Z});
        end
        onehot_en = 1'b1;
    endtask

    task automatic test_sweep();
        // Hand-computed XYZ indexed by {A1,A0,B1,B0}.
        logic [2:0] exp_tab [16] = '{
            3'b010, 3'b001, 3'b001, 3'b001,
            3'b100, 3'b010, 3'b001, 3'b001,
            3'b100, 3'b100, 3'b010, 3'b001,
            3'b100, 3'b100, 3'b100, 3'b010
        };
        for (int v = 0; v < 16; v++) begin
            @(negedge clk);
            {A1, A0, B1, B0} = 4'(v);
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                checks++;
                if ({X, Y, Z} !== exp_tab[v]) begin
                    errors++;
                    $display("FAIL sweep in=%b cyc=%0d XYZ=%b required %b", 4'(v), c, {X, Y, Z}, exp_tab[v]);
                end
            end
        end
    endtask

    task automatic test_latency();
        @(negedge clk);
        {A1, A0, B1, B0} = 4'b1001;     // A=2, B=1
        repeat (2) @(negedge clk);
        {A1, A0, B1, B0} = 4'b0110;     // A=1, B=2
        #0.5;
        checks++;
        if ({X, Y, Z} !== 3'b100) begin
            errors++;
            $display("FAIL latency_before XYZ=%b required 100", {X, Y, Z});
        end
        @(negedge clk);
        checks++;
        if ({X, Y, Z} !== 3'b001) begin
            errors++;
            $display("FAIL latency_after XYZ=%b required 001", {X, Y, Z});
        end
        @(negedge clk);
        checks++;
        if ({X, Y, Z} !== 3'b001) begin
            errors++;
            $display("FAIL latency_hold XYZ=%b required 001", {X, Y, Z});
        end
    endtask

`ifdef COMPARATOR_STATS_EN
    task automatic test_stats();
        logic [CNT_W-1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        @(negedge clk);
        onehot_en = 1'b0;
        rst_n = 1'b0;
        {A1, A0, B1, B0} = 4'b1111;
        #0.2;
        checks++;
        if (eq_cnt !== '0) begin
            errors++;
            $display("FAIL stats_reset0 eq_cnt=%0d required 0", eq_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (eq_cnt !== exp_cnt[i]) begin
                errors++;
                $display("FAIL stats_cnt edge=%0d eq_cnt=%0d required %0d", i + 1, eq_cnt, exp_cnt[i]);
            end
        end
        #0.5 rst_n = 1'b0;
        #0.2;
        checks++;
        if (eq_cnt !== '0) begin
            errors++;
            $display("FAIL stats_reset1 eq_cnt=%0d required 0", eq_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask
`endif

    initial begin
        #0.5 rst_n = 1'b0;
        #0.2;
        checks++;
        if ({X, Y, Z} !== 3'b000) begin
            errors++;
            $display("FAIL reset_initial XYZ=%b required 000", {X, Y, Z});
        end
        test_reset();
        test_sweep();
        test_latency();
`ifdef COMPARATOR_STATS_EN
        test_stats();
`endif
        onehot_en = 1'b0;
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
